// File: rtl/mem_arb_pkg.sv
// ------------------------------------------------------------------
// mem_arb_pkg: shared constants, owner type and pointer helper
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package mem_arb_pkg;

  localparam int NUM_REQ = 2;
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W   = 16;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef logic [IDX_W-1:0] owner_t;

  // Candidate k positions after ptr, wrapping over the requester set.
  function automatic owner_t rr_next(input owner_t ptr, input int k);
    return owner_t'((int'(ptr) + k) % NUM_REQ);
  endfunction

endpackage : mem_arb_pkg

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ------------------------------------------------------------------
// rr_arbiter: one-hot round-robin grant with a last-grant pointer
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module rr_arbiter
  import mem_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               gnt_any_o
);

  owner_t rr_ptr_q;
  owner_t rr_ptr_d;
  owner_t cand;

  // Search starts just past the last winner, so the last winner has lowest priority.
  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = rr_ptr_q;
    gnt_any_o = 1'b0;
    cand      = rr_ptr_q;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = rr_next(rr_ptr_q, k);
      if (!gnt_any_o && req_i[cand]) begin
        gnt_any_o = 1'b1;
        gnt_idx_o = cand;
      end
    end
    if (gnt_any_o) begin
      gnt_o[gnt_idx_o] = 1'b1;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_any_o) begin
      rr_ptr_d = gnt_idx_o;
    end
  end

  // Reset value makes requester 0 the first winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= owner_t'(NUM_REQ - 1);
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule : rr_arbiter

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ------------------------------------------------------------------
// mem_arbiter: two-requester round-robin front end to an external 1R1W memory
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 256,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] req_ready,
  input  logic [NUM_REQ-1:0] req_we,
  input  logic [AW-1:0]      req_addr0,
  input  logic [AW-1:0]      req_addr1,
  input  logic [WIDTH-1:0]   req_wdata0,
  input  logic [WIDTH-1:0]   req_wdata1,
  output logic [NUM_REQ-1:0] rsp_valid,
  output logic [WIDTH-1:0]   rsp_data,
  output logic               mem_we,
  output logic [AW-1:0]      mem_waddr,
  output logic [WIDTH-1:0]   mem_wdata,
  output logic [AW-1:0]      mem_raddr,
  input  logic [WIDTH-1:0]   mem_rdata,
  output logic [CNT_W-1:0]   grant_cnt0,
  output logic [CNT_W-1:0]   grant_cnt1
);

  logic [NUM_REQ-1:0] req_gated;
  logic [NUM_REQ-1:0] gnt;
  owner_t             gnt_idx;
  logic               gnt_any;
  logic               gnt_we;
  logic               rd_gnt;
  logic [AW-1:0]      gnt_addr;
  logic [WIDTH-1:0]   gnt_wdata;

  logic               rsp_pend_q;
  owner_t             rsp_owner_q;
  logic [AW-1:0]      raddr_q;

  logic [CNT_W-1:0]   cnt_q [NUM_REQ];
  logic [CNT_W-1:0]   cnt_d [NUM_REQ];

  // Grants are suppressed while reset is held so req_ready reads low.
  assign req_gated = req_valid & {NUM_REQ{rst_n}};

  rr_arbiter u_rr_arbiter (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req_gated),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_any_o (gnt_any)
  );

  assign req_ready = gnt;

  assign gnt_we    = req_we[gnt_idx];
  assign gnt_addr  = (gnt_idx == owner_t'(1)) ? req_addr1  : req_addr0;
  assign gnt_wdata = (gnt_idx == owner_t'(1)) ? req_wdata1 : req_wdata0;
  assign rd_gnt    = gnt_any & ~gnt_we;

  assign mem_we    = gnt_any & gnt_we;
  assign mem_waddr = gnt_addr;
  assign mem_wdata = gnt_wdata;

  // The read address passes straight through on a grant and is held otherwise.
  assign mem_raddr = rd_gnt ? gnt_addr : raddr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_pend_q  <= 1'b0;
      rsp_owner_q <= '0;
      raddr_q     <= '0;
    end else begin
      rsp_pend_q <= rd_gnt;
      if (rd_gnt) begin
        rsp_owner_q <= gnt_idx;
        raddr_q     <= gnt_addr;
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (rsp_pend_q) begin
      rsp_valid[rsp_owner_q] = 1'b1;
    end
  end

  assign rsp_data = rsp_pend_q ? mem_rdata : '0;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (gnt[i] && (cnt_q[i] != CNT_MAX)) begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign grant_cnt0 = cnt_q[0];
  assign grant_cnt1 = cnt_q[1];

endmodule : mem_arbiter

`default_nettype wire

// File: tb/tb_mem_arbiter.sv
// ------------------------------------------------------------------
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a behavioural memory
// Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_mem_arbiter;

  localparam int WIDTH = 32;
  localparam int DEPTH = 256;
  localparam int AW    = 8;

  typedef struct packed {
    logic             o;
    logic [WIDTH-1:0] d;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [1:0]       req_we;
  logic [AW-1:0]    req_addr0, req_addr1;
  logic [WIDTH-1:0] req_wdata0, req_wdata1;
  logic [1:0]       rsp_valid;
  logic [WIDTH-1:0] rsp_data;
  logic             mem_we;
  logic [AW-1:0]    mem_waddr, mem_raddr;
  logic [WIDTH-1:0] mem_wdata, mem_rdata;
  logic [15:0]      grant_cnt0, grant_cnt1;

  logic [WIDTH-1:0] mem    [DEPTH];
  logic [WIDTH-1:0] shadow [DEPTH];

  int   vec_cnt = 0;
  int   err_cnt = 0;
  exp_t sb[$];

  logic             m_ptr;
  logic [15:0]      m_cnt0, m_cnt1;
  logic [AW-1:0]    m_raddr;
  logic             m_any, m_g, m_we;
  logic [AW-1:0]    m_addr;
  logic [WIDTH-1:0] m_wd;
  exp_t             e;

  always #5 clk = ~clk;

  mem_arbiter #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_addr0  (req_addr0),
    .req_addr1  (req_addr1),
    .req_wdata0 (req_wdata0),
    .req_wdata1 (req_wdata1),
    .rsp_valid  (rsp_valid),
    .rsp_data   (rsp_data),
    .mem_we     (mem_we),
    .mem_waddr  (mem_waddr),
    .mem_wdata  (mem_wdata),
    .mem_raddr  (mem_raddr),
    .mem_rdata  (mem_rdata),
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
  );

  // Synchronous-read memory, data one cycle after the address.
  always @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    mem_rdata <= mem[mem_raddr];
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vec_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: round-robin prediction, shadow memory, counters.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_ready", req_ready, 2'b00);
      chk("rst_rsp_valid", rsp_valid, 2'b00);
      chk("rst_mem_we", mem_we, 1'b0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_raddr", mem_raddr, 0);
      chk("rst_cnt0", grant_cnt0, 0);
      chk("rst_cnt1", grant_cnt1, 0);
      sb.delete();
      m_ptr = 1'b1; m_cnt0 = '0; m_cnt1 = '0; m_raddr = '0;
    end else begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rsp_valid", rsp_valid, e.o ? 2'b10 : 2'b01);
        chk("rsp_data", rsp_data, e.d);
      end else begin
        chk("rsp_idle", rsp_valid, 2'b00);
      end
      chk("cnt0", grant_cnt0, m_cnt0);
      chk("cnt1", grant_cnt1, m_cnt1);

      m_any = |req_valid;
      if (req_valid == 2'b11) m_g = ~m_ptr;
      else                    m_g = req_valid[1];
      chk("ready", req_ready, m_any ? (m_g ? 2'b10 : 2'b01) : 2'b00);

      if (m_any) begin
        m_we   = req_we[m_g];
        m_addr = m_g ? req_addr1 : req_addr0;
        m_wd   = m_g ? req_wdata1 : req_wdata0;
        if (m_we) begin
          chk("wr_we", mem_we, 1'b1);
          chk("wr_addr", mem_waddr, m_addr);
          chk("wr_data", mem_wdata, m_wd);
          shadow[m_addr] = m_wd;
        end else begin
          chk("rd_we", mem_we, 1'b0);
          chk("rd_addr", mem_raddr, m_addr);
          e.o = m_g;
          e.d = shadow[m_addr];
          sb.push_back(e);
          m_raddr = m_addr;
        end
        m_ptr = m_g;
        if (!m_g && m_cnt0 != 16'hFFFF) m_cnt0 = m_cnt0 + 1'b1;
        if ( m_g && m_cnt1 != 16'hFFFF) m_cnt1 = m_cnt1 + 1'b1;
      end else begin
        chk("idle_we", mem_we, 1'b0);
        chk("idle_raddr", mem_raddr, m_raddr);
      end
    end
  end

  task automatic set_in(input logic [1:0] v, input logic [1:0] we,
                        input logic [AW-1:0] a0, input logic [WIDTH-1:0] d0,
                        input logic [AW-1:0] a1, input logic [WIDTH-1:0] d1);
    req_valid = v; req_we = we;
    req_addr0 = a0; req_wdata0 = d0;
    req_addr1 = a1; req_wdata1 = d1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_in(2'b00, 2'b00, 0, 0, 0, 0);
    step();
    step();
    rst_n = 1'b1;
  endtask

  logic got;

  initial begin
    rst_n = 1'b0;
    mem_rdata = '0;
    set_in(2'b00, 2'b00, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      mem[i] = '0;
      shadow[i] = '0;
    end
    mem[1] = 11; shadow[1] = 11;
    mem[2] = 22; shadow[2] = 22;
    repeat (3) step();
    rst_n = 1'b1;

    // write then read back on requester 0
    set_in(2'b01, 2'b01, 4, 42, 0, 0); step();
    set_in(2'b01, 2'b00, 4, 0, 0, 0);  step();
    set_in(2'b00, 2'b00, 0, 0, 0, 0);
    @(negedge clk);
    chk("t034_valid", rsp_valid, 2'b01);
    chk("t034_data", rsp_data, 42);
    step();
    step();

    // both reading: alternate grants, back-to-back responses
    do_reset();
    set_in(2'b11, 2'b00, 1, 0, 2, 0);
    @(negedge clk);
    chk("t035_g0", req_ready, 2'b01);
    step();
    set_in(2'b10, 2'b00, 1, 0, 2, 0);
    @(negedge clk);
    chk("t035_g1", req_ready, 2'b10);
    chk("t035_v0", rsp_valid, 2'b01);
    chk("t035_d0", rsp_data, 11);
    step();
    set_in(2'b00, 2'b00, 0, 0, 0, 0);
    @(negedge clk);
    chk("t035_v1", rsp_valid, 2'b10);
    chk("t035_d1", rsp_data, 22);
    step();

    // write by req1 immediately followed by read of the same word by req0
    set_in(2'b10, 2'b10, 0, 0, 7, 99); step();
    set_in(2'b01, 2'b00, 7, 0, 0, 0);  step();
    set_in(2'b00, 2'b00, 0, 0, 0, 0);
    @(negedge clk);
    chk("t036_valid", rsp_valid, 2'b01);
    chk("t036_data", rsp_data, 99);
    step();

    // reset right after a read grant drops the response
    set_in(2'b01, 2'b00, 4, 0, 0, 0); step();
    do_reset();
    set_in(2'b11, 2'b00, 1, 0, 2, 0);
    @(negedge clk);
    chk("t037_first", req_ready, 2'b01);
    step();
    set_in(2'b10, 2'b00, 1, 0, 2, 0); step();
    set_in(2'b00, 2'b00, 0, 0, 0, 0); step();
    step();

    // grant counter saturation
    do_reset();
    set_in(2'b01, 2'b00, 3, 0, 0, 0);
    repeat (70000) step();
    @(negedge clk);
    chk("t038_cnt0", grant_cnt0, 16'hFFFF);
    chk("t038_cnt1", grant_cnt1, 16'h0000);
    step();

    // requester 1 must not starve behind a continuous requester 0
    got = 1'b0;
    set_in(2'b11, 2'b00, 3, 0, 5, 0);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      if (req_ready[1]) got = 1'b1;
      step();
    end
    chk("t039_no_starve", got, 1'b1);
    set_in(2'b00, 2'b00, 0, 0, 0, 0);
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule : tb_mem_arbiter

`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits.
REQ-002 Parameter DEPTH, default 256, word count; AW = $clog2(DEPTH) (8 at default).
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  2  per-requester request valid (index 0/1).
REQ-006 req_ready  output  2  per-requester grant; the transfer happens when req_valid[i] & req_ready[i].
REQ-007 req_we  input  2  per-requester op select: 1 write, 0 read.
REQ-008 req_addr0, req_addr1  input  AW  per-requester word address.
REQ-009 req_wdata0, req_wdata1  input  WIDTH  per-requester write data.
REQ-010 rsp_valid  output  2  per-requester read-data strobe, one cycle wide.
REQ-011 rsp_data  output  WIDTH  read data, shared; qualified by rsp_valid.
REQ-012 mem_we  output  1  memory write enable.
REQ-013 mem_waddr, mem_wdata  output  AW, WIDTH  memory write port.
REQ-014 mem_raddr  output  AW  memory read address.
REQ-015 mem_rdata  input  WIDTH  memory read data, valid one cycle after mem_raddr is presented.
REQ-016 grant_cnt0, grant_cnt1  output  16  saturating per-requester grant counters.

Function
REQ-017 At most one req_ready bit shall be high per cycle; req_ready is combinational from req_valid and rr_ptr.
REQ-018 Arbitration shall be round-robin: with both valid, the requester != rr_ptr wins; with one valid, that one wins.
REQ-019 rr_ptr shall update to the granted index on each grant and hold when there is no grant.
REQ-020 The granted write shall drive mem_we=1, mem_waddr, mem_wdata in the grant cycle; mem_we=0 in every other cycle.
REQ-021 The granted read shall drive mem_raddr in the grant cycle; rsp_valid[i]=1 and rsp_data=mem_rdata exactly one cycle later.
REQ-022 Writes shall produce no rsp_valid.
REQ-023 mem_raddr shall hold its last value when there is no read grant; mem_waddr and mem_wdata are don't-care when mem_we=0.
REQ-024 Back-to-back reads (any mix of requesters) shall sustain one grant per cycle; the response pipeline is one entry deep, tagged with the owner index.
REQ-025 A write granted in cycle N followed by a read of the same address granted in cycle N+1 shall return the written data.
REQ-026 grant_cnt[i] shall increment on each grant to i and saturate at 16'hFFFF.
REQ-027 Dropping req_valid without a grant shall be legal; a requester shall hold addr, we and wdata stable while valid and not ready.

Reset
REQ-028 While rst_n=0, the block shall drive req_ready=0, rsp_valid=0, mem_we=0, rsp_data=0, mem_raddr=0, rr_ptr=1 (requester 0 wins first), and grant counters=0.
REQ-029 Reset asserted mid-operation shall discard the pending response; no rsp_valid shall follow reset release.
REQ-030 The first grant is possible in the first clock edge after rst_n rises.

Structure
REQ-031 Package mem_arb_pkg shall hold NUM_REQ=2, the owner_t typedef (1 bit), and the counter width constant CNT_W=16.
REQ-032 One sub-module, rr_arbiter (NUM_REQ-wide round-robin grant with last-grant pointer), shall implement REQ-017 to REQ-019.
REQ-033 The memory is instantiated outside the block and connected through the mem_* ports.

Verification
REQ-034 After reset: req0 write addr 4 data 42, then req0 read addr 4 -> rsp_valid=2'b01 one cycle after the read grant, rsp_data=42.
REQ-035 Both valid, both reading addrs 1 and 2 (preloaded 11 and 22) -> grants alternate 0,1; rsp_data is 11 then 22, with rsp_valid 01 then 10 in consecutive cycles.
REQ-036 req1 writes addr 7 = 99 in cycle N, req0 reads addr 7 in cycle N+1 -> rsp_data=99 on req0 in cycle N+2.
REQ-037 Read granted, rst_n pulsed low in the next cycle -> no rsp_valid; after release both valid -> req0 granted first.
REQ-038 req0 held valid for 70000 cycles -> grant_cnt0 saturates at 16'hFFFF, grant_cnt1=0.
REQ-039 req0 valid continuously, req1 asserts valid -> req1 granted within 2 cycles (no starvation).
